// File: rtl/arm_multicycle_controller.sv
// arm_multicycle_controller: multicycle ARM main FSM, ALU decoder, condition check and NZCV flags
module arm_multicycle_controller #(
  parameter int ALUC_W  = 3,
  parameter bit BL_EN   = 1'b1,
  parameter bit SKIP_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [19:0]       Instr,
  input  logic [3:0]        ALUFlags,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic              BrL,
  output logic [1:0]        ResultSrc,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic [1:0]        RegSrc,
  output logic [ALUC_W-1:0] ALUControl
);
  typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH} state_t;
  state_t state, state_n;
  logic [3:0] flags, cond, cmd;
  logic [1:0] op;
  logic [2:0] dec_c, alu_c;
  logic cond_ex, cond_ex_r, valid, cmp_tst, arith, rd15, pc_w, mem_w, ir_w, reg_w, n, z, c, v;
  assign cond = Instr[19:16];
  assign op = Instr[15:14];
  assign cmd = Instr[12:9];
  assign rd15 = Instr[3:0] == 4'hf;
  assign {n, z, c, v} = flags;
  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign cmp_tst = cmd == 4'b1010 || cmd == 4'b1000;
  assign arith = cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010;
  assign valid = arith || cmd == 4'b0000 || cmd == 4'b1000 || cmd == 4'b1100 || cmd == 4'b0001;
  assign dec_c = (cmd == 4'b0010 || cmd == 4'b1010) ? 3'b001 :
                 (cmd == 4'b0000 || cmd == 4'b1000) ? 3'b010 :
                 cmd == 4'b1100 ? 3'b011 : cmd == 4'b0001 ? 3'b100 : 3'b000;
  assign ALUControl = ALUC_W'(alu_c);
  assign PCWrite = pc_w && !reset;
  assign MemWrite = mem_w && !reset;
  assign IRWrite = ir_w && !reset;
  assign RegWrite = reg_w && !reset;
  always_comb begin
    case (cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = !z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = !c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = !n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = !v;
      4'h8: cond_ex = c && !z;
      4'h9: cond_ex = !c || z;
      4'ha: cond_ex = n == v;
      4'hb: cond_ex = n != v;
      4'hc: cond_ex = !z && n == v;
      4'hd: cond_ex = z || n != v;
      4'he: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      flags <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DECODE) cond_ex_r <= cond_ex;
      if ((state == EXECR || state == EXECI) && cond_ex_r && valid && (Instr[8] || cmp_tst)) begin
        flags[3:2] <= ALUFlags[3:2];
        if (arith) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end
  always_comb begin
    state_n = FETCH;
    pc_w = 1'b0;
    AdrSrc = 1'b0;
    mem_w = 1'b0;
    ir_w = 1'b0;
    reg_w = 1'b0;
    BrL = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    alu_c = 3'b000;
    case (state)
      FETCH: begin
        ir_w = 1'b1;
        pc_w = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        state_n = DECODE;
      end
      DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        state_n = (!cond_ex && SKIP_EN) ? FETCH : op == 2'b01 ? MEMADR :
                  op == 2'b00 ? (Instr[13] ? EXECI : EXECR) : op == 2'b10 ? BRANCH : FETCH;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        alu_c = Instr[11] ? 3'b000 : 3'b001;
        state_n = Instr[8] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        state_n = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w = cond_ex_r;
        pc_w = cond_ex_r && rd15;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_w = cond_ex_r;
      end
      EXECR, EXECI: begin
        ALUSrcB = state == EXECI ? 2'b01 : 2'b00;
        alu_c = dec_c;
        state_n = (valid && !cmp_tst) ? ALUWB : FETCH;
      end
      ALUWB: begin
        reg_w = cond_ex_r;
        pc_w = cond_ex_r && rd15;
      end
      BRANCH: begin
        ALUSrcB = 2'b01;
        ResultSrc = 2'b10;
        pc_w = cond_ex_r;
        BrL = BL_EN && Instr[12];
        reg_w = cond_ex_r && BL_EN && Instr[12];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_arm_multicycle_controller.sv
// tb_arm_multicycle_controller: scoreboard bench comparing per-cycle control outputs against an instruction model
module tb_arm_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0] ALUFlags = '0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, BrL, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [17:0] obs;
  logic [17:0] sb[$];
  logic [3:0] mflags = 4'b0000;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  arm_multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .BrL(BrL), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, BrL, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] v(input logic pcw, input logic adr, input logic mw, input logic irw,
                                    input logic rw, input logic brl, input logic [1:0] rs,
                                    input logic a, input logic [1:0] b, input logic [2:0] alu);
    return {pcw, adr, mw, irw, rw, brl, rs, a, b, alu};
  endfunction

  function automatic logic cond_ok(input logic [3:0] cd, input logic [3:0] f);
    logic base;
    case (cd[3:1])
      3'b000: base = f[2];
      3'b001: base = f[1];
      3'b010: base = f[3];
      3'b011: base = f[0];
      3'b100: base = f[1] & ~f[2];
      3'b101: base = f[3] ~^ f[0];
      3'b110: base = ~f[2] & (f[3] ~^ f[0]);
      default: return cd == 4'b1110;
    endcase
    return base ^ cd[0];
  endfunction

  task automatic expect_instr(input logic [31:0] w, input logic [3:0] af);
    logic [1:0] op;
    logic [3:0] ir;
    logic c, r15, st;
    logic [2:0] alu;
    int kind;
    logic ar;
    op = w[27:26];
    ir = {op, op == 2'b01, op == 2'b10};
    c = cond_ok(w[31:28], mflags);
    r15 = w[15:12] == 4'hf;
    st = w[20];
    sb.push_back({v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 3'b000), ir});
    sb.push_back({v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 3'b000), ir});
    if (!c) return;
    case (op)
      2'b01: begin
        sb.push_back({v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, w[23] ? 3'b000 : 3'b001), ir});
        if (w[20]) begin
          sb.push_back({v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000), ir});
          sb.push_back({v(r15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 3'b000), ir});
        end else
          sb.push_back({v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000), ir});
      end
      2'b00: begin
        ar = 1'b0;
        case (w[24:21])
          4'b0100: begin alu = 3'b000; kind = 1; ar = 1'b1; end
          4'b0010: begin alu = 3'b001; kind = 1; ar = 1'b1; end
          4'b0000: begin alu = 3'b010; kind = 1; end
          4'b1100: begin alu = 3'b011; kind = 1; end
          4'b0001: begin alu = 3'b100; kind = 1; end
          4'b1010: begin alu = 3'b001; kind = 2; ar = 1'b1; end
          4'b1000: begin alu = 3'b010; kind = 2; end
          default: begin alu = 3'b000; kind = 0; end
        endcase
        sb.push_back({v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, w[25] ? 2'b01 : 2'b00, alu), ir});
        if (kind != 0 && (st || kind == 2)) begin
          mflags[3:2] = af[3:2];
          if (ar) mflags[1:0] = af[1:0];
        end
        if (kind == 1)
          sb.push_back({v(r15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000), ir});
      end
      2'b10:
        sb.push_back({v(1'b1, 1'b0, 1'b0, 1'b0, w[24], w[24], 2'b10, 1'b0, 2'b01, 3'b000), ir});
      default: ;
    endcase
  endtask

  task automatic run(input string nm, input logic [31:0] w, input logic [3:0] af);
    Instr = w[31:12];
    ALUFlags = af;
    expect_instr(w, af);
    for (int k = 0; sb.size() > 0; k++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", nm, k), obs, sb.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Instr = 20'he0821;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_strobes", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    run("beq_flags0", 32'h0A000002, 4'b0000);
    run("add", 32'hE0821003, 4'b0000);
    run("subs", 32'hE0500000, 4'b0110);
    run("beq_taken", 32'h0A000002, 4'b0000);
    run("movne_skip", 32'h11A01002, 4'b0000);
    run("ldr_u0", 32'hE5101004, 4'b0000);
    run("str_u0", 32'hE5001004, 4'b0000);
    run("adds", 32'hE0921003, 4'b1000);
    run("beq_skip", 32'h0A000002, 4'b0000);
    run("bmi_taken", 32'h4A000002, 4'b0000);
    run("cmp", 32'hE1510001, 4'b0110);
    run("bne_skip", 32'h1A000002, 4'b0000);
    run("bcs_taken", 32'h2A000002, 4'b0000);
    run("bl", 32'hEB000001, 4'b0000);
    run("ldr_pc_u1", 32'hE59FF000, 4'b0000);
    run("eor_imm", 32'hE2211001, 4'b0000);
    run("orr", 32'hE1821003, 4'b0000);
    run("and", 32'hE0021003, 4'b0000);
    run("tst", 32'hE1110002, 4'b0001);
    run("beq_after_tst", 32'h0A000002, 4'b0000);
    run("bcs_after_tst", 32'h2A000002, 4'b0000);
    run("mov_unsup", 32'hE3A01002, 4'b0000);
    run("undef_op11", 32'hEC000000, 4'b0000);
    run("add_pc", 32'hE082F003, 4'b0000);
    run("never", 32'hF0821003, 4'b0000);
    run("cmp2", 32'hE1510001, 4'b0110);
    Instr = 20'he5001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    chk("str_memwr_reached", MemWrite, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_strobes", {PCWrite, IRWrite, RegWrite, MemWrite}, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b0;
    mflags = 4'b0000;
    run("beq_after_rst", 32'h0A000002, 4'b0000);
    @(negedge clk);
    chk("end_fetch", IRWrite, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
